// File: rtl/mac_dot_sequencer_if.sv
// Operand-stream, MAC-drive and result ports of the dot-product sequencer.
// master = sequencer side, slave = environment (source, MAC, consumer).
interface mac_dot_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_m;
    logic [DATA_WIDTH-1:0] in_q;
    logic                  in_last;

    logic                  mac_start;
    logic                  mac_clr_acc;
    logic [DATA_WIDTH-1:0] mac_m;
    logic [DATA_WIDTH-1:0] mac_q;
    logic                  mac_ready;
    logic [39:0]           mac_product;

    logic                  res_valid;
    logic                  res_ready;
    logic [39:0]           res_data;
    logic                  res_sat;
    logic                  busy;

    modport master (
        input  in_valid, in_m, in_q, in_last,
        input  mac_ready, mac_product, res_ready,
        output in_ready, mac_start, mac_clr_acc, mac_m, mac_q,
        output res_valid, res_data, res_sat, busy
    );

    modport slave (
        output in_valid, in_m, in_q, in_last,
        output mac_ready, mac_product, res_ready,
        input  in_ready, mac_start, mac_clr_acc, mac_m, mac_q,
        input  res_valid, res_data, res_sat, busy
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams buffered operand pairs through a single-shot MAC, returns dot products.
// Optional MAC_SEQ_SAT_EN clamps results to signed 32-bit and flags res_sat.
module mac_dot_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input logic                clk,
    input logic                rst_n,
    mac_dot_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] m;
        logic [DATA_WIDTH-1:0] q;
        logic                  last;
    } pair_t;

    typedef enum logic [2:0] {
        IDLE, CLEAR, ISSUE, WAIT, SETTLE, RESULT
    } state_t;

    state_t state, state_n;

    pair_t          mem [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty, push, pop;
    pair_t          head;

    logic [DATA_WIDTH-1:0] mac_m_r, mac_q_r;
    logic           cur_last, in_vector;
    logic [39:0]    res_data_r, cap_data;
    logic           res_sat_r, cap_sat;
    logic           set_vec, clr_vec, capture;

    // Extra pointer bit separates full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{bus.in_m, bus.in_q, bus.in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (!empty) state_n = in_vector ? ISSUE : CLEAR;
            CLEAR:  state_n = ISSUE;
            ISSUE:  state_n = WAIT;
            WAIT: begin
                if (bus.mac_ready) begin
                    if (cur_last)   state_n = SETTLE;
                    else if (empty) state_n = IDLE;
                    else            state_n = ISSUE;
                end
            end
            SETTLE: state_n = RESULT;
            RESULT: if (bus.res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        set_vec = 1'b0;
        clr_vec = 1'b0;
        capture = 1'b0;
        unique case (1'b1)
            (state == IDLE):  pop = !empty && in_vector;
            (state == CLEAR): begin
                pop     = 1'b1;
                set_vec = 1'b1;
            end
            (state == WAIT): begin
                pop     = bus.mac_ready && !cur_last && !empty;
                clr_vec = bus.mac_ready && cur_last;
            end
            (state == SETTLE): capture = 1'b1;
            default: ;
        endcase
    end

`ifdef MAC_SEQ_SAT_EN
    localparam logic signed [39:0] SAT_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [39:0] SAT_MIN = 40'shFF_8000_0000;

    always_comb begin
        cap_data = bus.mac_product;
        cap_sat  = 1'b0;
        if ($signed(bus.mac_product) > SAT_MAX) begin
            cap_data = SAT_MAX;
            cap_sat  = 1'b1;
        end else if ($signed(bus.mac_product) < SAT_MIN) begin
            cap_data = SAT_MIN;
            cap_sat  = 1'b1;
        end
    end
`else
    assign cap_data = bus.mac_product;
    assign cap_sat  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mac_m_r    <= '0;
            mac_q_r    <= '0;
            cur_last   <= 1'b0;
            in_vector  <= 1'b0;
            res_data_r <= '0;
            res_sat_r  <= 1'b0;
        end else begin
            if (pop) begin
                mac_m_r  <= head.m;
                mac_q_r  <= head.q;
                cur_last <= head.last;
            end
            if (set_vec)      in_vector <= 1'b1;
            else if (clr_vec) in_vector <= 1'b0;
            if (capture) begin
                res_data_r <= cap_data;
                res_sat_r  <= cap_sat;
            end
        end
    end

    assign bus.in_ready    = !full;
    assign bus.mac_start   = (state == ISSUE);
    assign bus.mac_clr_acc = (state == CLEAR);
    assign bus.mac_m       = mac_m_r;
    assign bus.mac_q       = mac_q_r;
    assign bus.res_valid   = (state == RESULT);
    assign bus.res_data    = res_data_r;
    assign bus.res_sat     = res_sat_r;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC, vector table and corner sequences.
// Expected saturation results follow MAC_SEQ_SAT_EN.
module tb_mac_dot_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    mac_dot_sequencer #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural MAC: ready pulses lat+1 cycles after start unless stalled
    int                 lat = 1;
    bit                 stall = 1'b0;
    int                 cnt;
    logic               rdy;
    logic signed [39:0] acc;

    assign bus.mac_ready   = rdy;
    assign bus.mac_product = acc;

    always @(posedge clk) begin
        if (rst_n) begin
            cnt <= 0;
            rdy <= 1'b0;
            acc <= '0;
        end else begin
            rdy <= 1'b0;
            if (bus.mac_clr_acc) acc <= '0;
            if (bus.mac_start) cnt <= lat;
            else if (cnt > 1) cnt <= cnt - 1;
            else if (cnt == 1 && !stall) begin
                cnt <= 0;
                rdy <= 1'b1;
                acc <= acc + $signed(bus.mac_m) * $signed(bus.mac_q);
            end
        end
    end

    int          cyc = 0, starts = 0, clears = 0;
    int          rdy_cyc = 0, rv_cyc = 0, clr_cyc = -10;
    int          clr_start = 0, fast = 0;
    logic        prev_rv = 1'b0;
    logic [15:0] log_m [256];

    always @(negedge clk) begin
        cyc++;
        if (bus.mac_start) begin
            log_m[starts % 256] = bus.mac_m;
            starts++;
            if (cyc == clr_cyc + 1) clr_start++;
            if (cyc == rdy_cyc + 1) fast++;
        end
        if (bus.mac_clr_acc) begin
            clears++;
            clr_cyc = cyc;
        end
        if (bus.mac_ready) rdy_cyc = cyc;
        if (bus.res_valid && !prev_rv) rv_cyc = cyc;
        prev_rv = bus.res_valid;
    end

    int checks = 0, errors = 0, accepted = 0;

    task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(int m, int q, bit last);
        bit ok = 1'b0;
        int g = 0;
        bus.in_m     = 16'(m);
        bus.in_q     = 16'(q);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!ok && g < 500) begin
            @(negedge clk);
            ok = bus.in_ready;
            g++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (ok) accepted++;
        else chk("push_timeout", 40'(ok), 40'd1);
    endtask

    task automatic wait_res();
        int g = 0;
        bit seen = 1'b0;
        while (!seen && g < 3000) begin
            @(negedge clk);
            seen = bus.res_valid;
            g++;
        end
        if (!seen) chk("res_timeout", 40'(seen), 40'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic accept(string nm);
        logic [39:0] snap;
        snap = bus.res_data;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_held"}, {38'd0, bus.res_valid, 1'b0} | 40'(bus.res_data != snap),
            40'd2);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_drop"}, 40'(bus.res_valid), 40'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        int          m [4];
        int          q [4];
        int          lat;
        logic [39:0] exp;
        logic        sat;
    } vec_t;

`ifdef MAC_SEQ_SAT_EN
    localparam logic [39:0] E_POS = 40'h00_7FFF_FFFF;
    localparam logic [39:0] E_NEG = 40'hFF_8000_0000;
    localparam logic        E_SAT = 1'b1;
`else
    localparam logic [39:0] E_POS = 40'h00_FFFC_0004;
    localparam logic [39:0] E_NEG = 40'hFF_0002_0000;
    localparam logic        E_SAT = 1'b0;
`endif

    vec_t vt [5];

    initial begin
        int s0, c0, k0, f0, bad;
        logic [39:0] snap;

        vt[0] = '{1, '{3, 0, 0, 0}, '{4, 0, 0, 0}, 1, 40'd12, 1'b0};
        vt[1] = '{4, '{1, -3, 7, -2}, '{2, 5, -1, -2}, 2,
                  40'hFF_FFFF_FFF0, 1'b0};
        vt[2] = '{4, '{32767, 32767, 32767, 32767},
                  '{32767, 32767, 32767, 32767}, 3, E_POS, E_SAT};
        vt[3] = '{2, '{-1, -32768, 0, 0}, '{-1, -32768, 0, 0}, 1,
                  40'h00_4000_0001, 1'b0};
        vt[4] = '{4, '{-32768, -32768, -32768, -32768},
                  '{32767, 32767, 32767, 32767}, 4, E_NEG, E_SAT};

        bus.in_valid  = 1'b0;
        bus.in_m      = '0;
        bus.in_q      = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 40'(bus.busy), 40'd0);
        chk("rst_in_ready", 40'(bus.in_ready), 40'd1);
        chk("rst_res_valid", 40'(bus.res_valid), 40'd0);
        chk("rst_start_clr", {38'd0, bus.mac_start, bus.mac_clr_acc}, 40'd0);
        chk("rst_mac_mq", {8'd0, bus.mac_m, bus.mac_q}, 40'd0);
        chk("rst_res", bus.res_data | 40'(bus.res_sat), 40'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        for (int e = 0; e < 5; e++) begin
            lat = vt[e].lat;
            s0 = starts;
            c0 = clears;
            k0 = clr_start;
            f0 = fast;
            for (int i = 0; i < vt[e].n; i++)
                push(vt[e].m[i], vt[e].q[i], i == vt[e].n - 1);
            wait_res();
            chk($sformatf("v%0d_data", e), bus.res_data, vt[e].exp);
            chk($sformatf("v%0d_sat", e), 40'(bus.res_sat), 40'(vt[e].sat));
            chk($sformatf("v%0d_starts", e), 40'(starts - s0), 40'(vt[e].n));
            chk($sformatf("v%0d_clears", e), 40'(clears - c0), 40'd1);
            chk($sformatf("v%0d_clr_to_start", e), 40'(clr_start - k0), 40'd1);
            chk($sformatf("v%0d_back_to_back", e), 40'(fast - f0),
                40'(vt[e].n - 1));
            chk($sformatf("v%0d_res_latency", e), 40'(rv_cyc - rdy_cyc), 40'd2);
            accept($sformatf("v%0d", e));
        end

        // MAC stalled: one pair in the MAC plus a full FIFO, then drain in order
        lat = 1;
        stall = 1'b1;
        accepted = 0;
        s0 = starts;
        fork
            begin
                for (int i = 0; i < 12; i++) push(i + 1, 1, i == 11);
            end
        join_none
        repeat (40) @(posedge clk);
        #1;
        chk("stall_accepted", 40'(accepted), 40'd9);
        chk("stall_in_ready", 40'(bus.in_ready), 40'd0);
        stall = 1'b0;
        wait_res();
        chk("stall_data", bus.res_data, 40'd78);
        chk("stall_starts", 40'(starts - s0), 40'd12);
        bad = 0;
        for (int i = 0; i < 12; i++)
            if (log_m[(s0 + i) % 256] != 16'(i + 1)) bad++;
        chk("stall_order", 40'(bad), 40'd0);
        accept("stall");

        // Result back-pressure with the next vector already queued
        push(2, 3, 1'b1);
        wait_res();
        chk("bp_first", bus.res_data, 40'd6);
        s0 = starts;
        c0 = clears;
        push(3, 4, 1'b1);
        snap = bus.res_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_data != snap) bad++;
        end
        chk("bp_stable", 40'(bad), 40'd0);
        chk("bp_no_activity", 40'(starts - s0 + clears - c0), 40'd0);
        @(posedge clk);
        #1;
        accept("bp");
        wait_res();
        chk("bp_next_data", bus.res_data, 40'd12);
        chk("bp_next_clear", 40'(clears - c0), 40'd1);
        accept("bp_next");

        // Reset while waiting on the MAC
        stall = 1'b1;
        s0 = starts;
        push(1, 1, 1'b0);
        push(2, 2, 1'b1);
        for (int g = 0; g < 50 && starts == s0; g++) begin
            @(posedge clk);
            #1;
        end
        chk("rw_started", 40'(starts - s0), 40'd1);
        @(posedge clk);
        #1;
        chk("rw_busy", 40'(bus.busy), 40'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("rw_busy_rst", 40'(bus.busy), 40'd0);
        chk("rw_in_ready", 40'(bus.in_ready), 40'd1);
        chk("rw_mac_mq", {8'd0, bus.mac_m, bus.mac_q}, 40'd0);
        chk("rw_res", bus.res_data | 40'(bus.res_valid) | 40'(bus.res_sat), 40'd0);
        repeat (5) @(negedge clk);
        chk("rw_fifo_empty", 40'(bus.busy), 40'd0);
        @(posedge clk);
        #1;
        c0 = clears;
        push(5, 6, 1'b1);
        wait_res();
        chk("rw_data", bus.res_data, 40'd30);
        chk("rw_fresh_clear", 40'(clears - c0), 40'd1);
        accept("rw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
